// File: rtl/blackjack_pkg.sv
// Shared deck constants, suit encoding and dealer state encoding.
package blackjack_pkg;

  localparam int DECK_SIZE = 52;
  localparam int IDX_W     = 6;

  typedef enum logic [1:0] {
    HEARTS   = 2'd0,
    DIAMONDS = 2'd1,
    CLUBS    = 2'd2,
    SPADES   = 2'd3
  } suit_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQUEST = 3'd1,
    SAMPLE  = 3'd2,
    PROBE   = 3'd3,
    DELIVER = 3'd4
  } dealer_state_t;

endpackage

// File: rtl/card_decoder.sv
// Combinational map from card index (0..51) to rank, suit and blackjack points.
// Suits occupy consecutive runs of 13 indices; rank 1 is the ace.
module card_decoder #(
  parameter int IDX_W = 6
) (
  input  logic [IDX_W-1:0] idx,
  output logic [3:0]       rank,
  output logic [1:0]       suit,
  output logic [3:0]       points
);
  import blackjack_pkg::*;

  logic [3:0] off;

  always_comb begin
    off  = idx[3:0];
    suit = HEARTS;
    if (idx >= IDX_W'(39)) begin
      off  = 4'(idx - IDX_W'(39));
      suit = SPADES;
    end else if (idx >= IDX_W'(26)) begin
      off  = 4'(idx - IDX_W'(26));
      suit = CLUBS;
    end else if (idx >= IDX_W'(13)) begin
      off  = 4'(idx - IDX_W'(13));
      suit = DIAMONDS;
    end
    rank = off + 4'd1;
    if (rank == 4'd1)
      points = 4'd11;
    else if (rank >= 4'd10)
      points = 4'd10;
    else
      points = rank;
  end

endmodule

// File: rtl/deck_dealer.sv
// Deals cards without repetition using a random start slot and linear probing of a dealt mask.
// deal_req to card_valid is 4 cycles plus one per occupied slot; deal_req while busy is dropped.
module deck_dealer #(
  parameter int DECK_SIZE = 52,
  parameter int IDX_W     = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             shuffle,
  input  logic             deal_req,
  input  logic [IDX_W-1:0] rnd_value,
  output logic             rnd_request,
  output logic             card_valid,
  output logic [IDX_W-1:0] card_index,
  output logic [3:0]       card_rank,
  output logic [1:0]       card_suit,
  output logic [3:0]       card_points,
  output logic             busy,
  output logic             deck_empty,
  output logic [IDX_W-1:0] cards_remaining,
  output logic             deal_error
);
  import blackjack_pkg::*;

  localparam logic [IDX_W-1:0] DECK_N    = IDX_W'(DECK_SIZE);
  localparam logic [IDX_W-1:0] DECK_LAST = IDX_W'(DECK_SIZE - 1);

  dealer_state_t        state;
  logic [DECK_SIZE-1:0] dealt;
  logic [IDX_W-1:0]     cand;
  logic [3:0]           dec_rank;
  logic [1:0]           dec_suit;
  logic [3:0]           dec_points;

  card_decoder #(.IDX_W(IDX_W)) u_decoder (
    .idx    (cand),
    .rank   (dec_rank),
    .suit   (dec_suit),
    .points (dec_points)
  );

  assign busy       = (state != IDLE);
  assign deck_empty = (cards_remaining == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      dealt           <= '0;
      cand            <= '0;
      cards_remaining <= DECK_N;
      rnd_request     <= 1'b0;
      card_valid      <= 1'b0;
      deal_error      <= 1'b0;
      card_index      <= '0;
      card_rank       <= '0;
      card_suit       <= '0;
      card_points     <= '0;
    end else begin
      rnd_request <= 1'b0;
      card_valid  <= 1'b0;
      deal_error  <= 1'b0;
      if (shuffle) begin
        state           <= IDLE;
        dealt           <= '0;
        cards_remaining <= DECK_N;
      end else begin
        case (state)
          IDLE: begin
            if (deal_req) begin
              if (cards_remaining == '0) begin
                deal_error <= 1'b1;
              end else begin
                state       <= REQUEST;
                rnd_request <= 1'b1;
              end
            end
          end
          REQUEST: state <= SAMPLE;
          SAMPLE: begin
            // The generator range is at most 63, so one fold brings it into 0..51.
            cand  <= (rnd_value >= DECK_N) ? rnd_value - DECK_N : rnd_value;
            state <= PROBE;
          end
          PROBE: begin
            // Card outputs are registered on the way into DELIVER so they are valid there.
            if (!dealt[cand]) begin
              dealt[cand]     <= 1'b1;
              cards_remaining <= cards_remaining - 1'b1;
              card_valid      <= 1'b1;
              card_index      <= cand;
              card_rank       <= dec_rank;
              card_suit       <= dec_suit;
              card_points     <= dec_points;
              state           <= DELIVER;
            end else begin
              cand <= (cand == DECK_LAST) ? '0 : cand + 1'b1;
            end
          end
          DELIVER: state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
